// File: rtl/demux_1ton_stream_if.sv
// Stream bundle for demux_1ton_stream: one input stream fanning out to NUM_CH
// independent output streams.
interface demux_1ton_stream_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0]        din;
  logic                     din_valid;
  logic                     din_ready;
  logic [SEL_W-1:0]         sel;
  logic                     bcast;
  logic [NUM_CH*DATA_W-1:0] dout;
  logic [NUM_CH-1:0]        dout_valid;
  logic [NUM_CH-1:0]        dout_ready;

  modport master (
    output din, din_valid, sel, bcast, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, sel, bcast, dout_ready,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/demux_1ton_stream.sv
// 1-to-N stream demultiplexer: per-channel 1-deep holding register, unicast or
// broadcast routing, and discard/count of beats addressed to a missing channel.
module demux_1ton_stream #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1ton_stream_if.slave bus,
  output logic               sel_err,
  output logic [7:0]         drop_cnt
);
  localparam int SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam logic [SEL_W:0] NumChW = (SEL_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0]        drain, sel_hit, load;
  logic                     in_range, sel_free, all_free, ready, accept, drop;
  logic                     sel_err_q, sel_err_d;
  logic [7:0]               drop_cnt_q, drop_cnt_d;

  always_comb begin
    in_range = ({1'b0, bus.sel} < NumChW);
    drain    = valid_q & bus.dout_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_hit[k] = (bus.sel == SEL_W'(k));
    end
    // A channel can take a beat if empty or being emptied on this same edge.
    sel_free = |(sel_hit & (~valid_q | drain));
    all_free = &(~valid_q | drain);

    if (bus.bcast) begin
      ready = all_free;
    end else if (in_range) begin
      ready = sel_free;
    end else begin
      ready = 1'b1;
    end

    accept = bus.din_valid & ready;
    load   = {NUM_CH{accept}} & (bus.bcast ? {NUM_CH{1'b1}} : sel_hit);
    drop   = accept & ~bus.bcast & ~in_range;
  end

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    sel_err_d  = sel_err_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (load[k]) begin
        valid_d[k]                   = 1'b1;
        data_d[k*DATA_W +: DATA_W]   = bus.din;
      end else if (drain[k]) begin
        // Empty slots read as zero so idle channels never show stale data.
        valid_d[k]                   = 1'b0;
        data_d[k*DATA_W +: DATA_W]   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      data_q     <= '0;
      sel_err_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      sel_err_q  <= sel_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.din_ready  = ready;
  assign bus.dout       = data_q;
  assign bus.dout_valid = valid_q;
  assign sel_err        = sel_err_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Directed and scoreboarded checks of demux_1ton_stream on three configurations:
// defaults, NUM_CH=3, and NUM_CH=5/DATA_W=16.
module tb_demux_1ton_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  demux_1ton_stream_if #(.DATA_W(8),  .NUM_CH(4)) bus_a ();
  demux_1ton_stream_if #(.DATA_W(8),  .NUM_CH(3)) bus_b ();
  demux_1ton_stream_if #(.DATA_W(16), .NUM_CH(5)) bus_c ();

  logic       sel_err_a, sel_err_b, sel_err_c;
  logic [7:0] drop_cnt_a, drop_cnt_b, drop_cnt_c;

  demux_1ton_stream #(.DATA_W(8), .NUM_CH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .sel_err(sel_err_a), .drop_cnt(drop_cnt_a)
  );
  demux_1ton_stream #(.DATA_W(8), .NUM_CH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .sel_err(sel_err_b), .drop_cnt(drop_cnt_b)
  );
  demux_1ton_stream #(.DATA_W(16), .NUM_CH(5)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c), .sel_err(sel_err_c), .drop_cnt(drop_cnt_c)
  );

  logic [15:0] q_c [5][$];
  int          drops_c = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] slice_a(input int k);
    return bus_a.dout[k*8 +: 8];
  endfunction

  function automatic logic [15:0] slice_c(input int k);
    return bus_c.dout[k*16 +: 16];
  endfunction

  initial begin
    logic [4:0] free_c;
    logic       exp_ready;
    logic [7:0] exp_cnt;

    bus_a.din = '0; bus_a.din_valid = 1'b0; bus_a.sel = '0; bus_a.bcast = 1'b0;
    bus_a.dout_ready = '1;
    bus_b.din = '0; bus_b.din_valid = 1'b0; bus_b.sel = '0; bus_b.bcast = 1'b0;
    bus_b.dout_ready = '1;
    bus_c.din = '0; bus_c.din_valid = 1'b0; bus_c.sel = '0; bus_c.bcast = 1'b0;
    bus_c.dout_ready = '1;

    // Reset values
    #2;
    check("rst_valid",     64'(bus_a.dout_valid), 64'h0);
    check("rst_dout",      64'(bus_a.dout),       64'h0);
    check("rst_sel_err",   64'(sel_err_a),        64'h0);
    check("rst_drop_cnt",  64'(drop_cnt_a),       64'h0);
    check("rst_ready_uni", 64'(bus_a.din_ready),  64'h1);
    bus_a.bcast = 1'b1;
    #1;
    check("rst_ready_bc",  64'(bus_a.din_ready),  64'h1);
    bus_a.bcast = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single unicast beat, one cycle latency, then empties
    bus_a.din = 8'hA5; bus_a.sel = 2'd2; bus_a.din_valid = 1'b1;
    @(negedge clk);
    bus_a.din_valid = 1'b0;
    check("uni_valid", 64'(bus_a.dout_valid), 64'h4);
    check("uni_dout",  64'(bus_a.dout),       64'h00A5_0000);
    @(negedge clk);
    check("uni_empty_valid", 64'(bus_a.dout_valid), 64'h0);
    check("uni_empty_dout",  64'(bus_a.dout),       64'h0);

    // Backpressure on channel 1, then drain+load on the same edge
    bus_a.dout_ready = 4'b1101;
    bus_a.din = 8'h11; bus_a.sel = 2'd1; bus_a.din_valid = 1'b1;
    @(negedge clk);
    check("hold_valid", 64'(bus_a.dout_valid), 64'h2);
    check("hold_first", 64'(slice_a(1)),       64'h11);
    bus_a.din = 8'h22;
    #1;
    check("hold_ready", 64'(bus_a.din_ready), 64'h0);
    @(negedge clk);
    check("hold_stable", 64'(slice_a(1)), 64'h11);
    bus_a.dout_ready = 4'hF;
    #1;
    check("hold_ready_drain", 64'(bus_a.din_ready), 64'h1);
    @(negedge clk);
    bus_a.din_valid = 1'b0;
    check("hold_reload_valid", 64'(bus_a.dout_valid), 64'h2);
    check("hold_second",       64'(slice_a(1)),       64'h22);
    @(negedge clk);
    check("hold_empty", 64'(bus_a.dout_valid), 64'h0);

    // Broadcast blocked by stalled channel 3; unicast elsewhere still flows
    bus_a.dout_ready = 4'b0111;
    bus_a.din = 8'h77; bus_a.sel = 2'd3; bus_a.din_valid = 1'b1;
    @(negedge clk);
    bus_a.din = 8'h5A; bus_a.bcast = 1'b1;
    #1;
    check("bc_blocked", 64'(bus_a.din_ready), 64'h0);
    @(negedge clk);
    check("bc_not_taken", 64'(bus_a.dout_valid), 64'h8);
    bus_a.bcast = 1'b0; bus_a.sel = 2'd0; bus_a.din = 8'h01;
    #1;
    check("uni_past_stall", 64'(bus_a.din_ready), 64'h1);
    @(negedge clk);
    check("uni_past_valid", 64'(bus_a.dout_valid), 64'h9);
    check("uni_past_data",  64'(slice_a(0)),       64'h01);
    check("stall_held",     64'(slice_a(3)),       64'h77);
    bus_a.bcast = 1'b1; bus_a.din = 8'h5A; bus_a.dout_ready = 4'hF;
    #1;
    check("bc_ready", 64'(bus_a.din_ready), 64'h1);
    @(negedge clk);
    bus_a.din_valid = 1'b0; bus_a.bcast = 1'b0;
    check("bc_valid", 64'(bus_a.dout_valid), 64'hF);
    check("bc_dout",  64'(bus_a.dout),       64'h5A5A_5A5A);
    @(negedge clk);
    check("bc_empty", 64'(bus_a.dout_valid), 64'h0);

    // Out-of-range sel on NUM_CH=3: discard, sticky error, saturating count
    check("b_err_init", 64'(sel_err_b), 64'h0);
    bus_b.sel = 2'd3; bus_b.din = 8'hEE; bus_b.din_valid = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      #1;
      check("b_ready", 64'(bus_b.din_ready), 64'h1);
      @(negedge clk);
      check("b_valid", 64'(bus_b.dout_valid), 64'h0);
      if (i == 1) begin
        check("b_cnt_1", 64'(drop_cnt_b), 64'd1);
        check("b_err_1", 64'(sel_err_b),  64'h1);
      end
      if (i == 255) check("b_cnt_255", 64'(drop_cnt_b), 64'd255);
    end
    bus_b.din_valid = 1'b0;
    check("b_cnt_sat", 64'(drop_cnt_b), 64'd255);
    check("b_err_sticky", 64'(sel_err_b), 64'h1);

    // Random traffic on NUM_CH=5, DATA_W=16 against per-channel queues
    for (int cyc = 0; cyc < 404; cyc++) begin
      if (cyc < 400) begin
        bus_c.din_valid  = ($urandom_range(0, 3) != 0);
        bus_c.din        = 16'($urandom);
        bus_c.bcast      = ($urandom_range(0, 7) == 0);
        bus_c.sel        = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                       : 3'($urandom_range(0, 4));
        bus_c.dout_ready = 5'($urandom);
      end else begin
        bus_c.din_valid  = 1'b0;
        bus_c.bcast      = 1'b0;
        bus_c.dout_ready = '1;
      end
      #1;
      for (int k = 0; k < 5; k++) begin
        free_c[k] = (q_c[k].size() == 0) || bus_c.dout_ready[k];
      end
      if (bus_c.bcast)     exp_ready = &free_c;
      else if (bus_c.sel < 3'd5) exp_ready = free_c[bus_c.sel];
      else                 exp_ready = 1'b1;
      check("c_ready", 64'(bus_c.din_ready), 64'(exp_ready));
      for (int k = 0; k < 5; k++) begin
        check("c_valid", 64'(bus_c.dout_valid[k]), 64'(q_c[k].size() != 0));
        if (q_c[k].size() != 0) begin
          check("c_data", 64'(slice_c(k)), 64'(q_c[k][0]));
          if (bus_c.dout_ready[k]) void'(q_c[k].pop_front());
        end else begin
          check("c_zero", 64'(slice_c(k)), 64'h0);
        end
      end
      if (bus_c.din_valid && exp_ready) begin
        if (bus_c.bcast) begin
          for (int k = 0; k < 5; k++) q_c[k].push_back(bus_c.din);
        end else if (bus_c.sel < 3'd5) begin
          q_c[bus_c.sel].push_back(bus_c.din);
        end else begin
          drops_c++;
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) check("c_left", 64'(q_c[k].size()), 64'h0);
    check("c_final_valid", 64'(bus_c.dout_valid), 64'h0);
    exp_cnt = (drops_c > 255) ? 8'd255 : 8'(drops_c);
    check("c_drop_cnt", 64'(drop_cnt_c), 64'(exp_cnt));
    check("c_sel_err",  64'(sel_err_c),  64'(drops_c != 0));

    // Asynchronous reset while channels 0 and 2 hold beats
    bus_a.dout_ready = 4'h0;
    bus_a.din = 8'hC0; bus_a.sel = 2'd0; bus_a.din_valid = 1'b1;
    @(negedge clk);
    bus_a.din = 8'hC2; bus_a.sel = 2'd2;
    @(negedge clk);
    bus_a.din_valid = 1'b0;
    check("pre_rst_valid", 64'(bus_a.dout_valid), 64'h5);
    rst_n = 1'b0;
    #1;
    check("arst_valid",    64'(bus_a.dout_valid), 64'h0);
    check("arst_dout",     64'(bus_a.dout),       64'h0);
    check("arst_ready",    64'(bus_a.din_ready),  64'h1);
    check("arst_b_cnt",    64'(drop_cnt_b),       64'h0);
    check("arst_b_err",    64'(sel_err_b),        64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.dout_ready = 4'hF;
    bus_a.din = 8'h3C; bus_a.sel = 2'd0; bus_a.din_valid = 1'b1;
    @(negedge clk);
    bus_a.din_valid = 1'b0;
    check("post_rst_valid", 64'(bus_a.dout_valid), 64'h1);
    check("post_rst_data",  64'(slice_a(0)),       64'h3C);
    @(negedge clk);
    check("post_rst_empty", 64'(bus_a.dout_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_1ton_stream.md
DEMUX_1TON_STREAM -- requirements
Module: demux_1ton_stream

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, legal range 1..64.
REQ-002 Parameter NUM_CH, default 4: number of output channels, legal range 2..16, need not be a power of two.
REQ-003 Derived width SEL_W = max(1, ceil(log2(NUM_CH))); it is not overridable.
REQ-004 Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_W  input payload.
- din_valid  input  1  input beat present.
- din_ready  output  1  block accepts a beat this cycle.
- sel  input  SEL_W  target channel; sampled with din.
- bcast  input  1  1 = copy the beat to all channels (sel ignored); sampled with din.
- dout  output  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- dout_valid  output  NUM_CH  per-channel beat present.
- dout_ready  input  NUM_CH  per-channel sink accepts.
- sel_err  output  1  sticky: an out-of-range sel was accepted.
- drop_cnt  output  8  count of beats dropped for out-of-range sel, saturating.
REQ-005 The single clock is clk; reset is rst_n, asynchronous assertion, active-low, with no other clock or reset input.

Function
REQ-006 Each channel SHALL own a 1-deep holding register with states EMPTY (dout_valid[k]=0) and FULL (dout_valid[k]=1).
REQ-007 A channel drains when dout_valid[k] and dout_ready[k] are both 1 at a clock edge.
- Transition FULL->EMPTY on a drain with no simultaneous load.
- Transition FULL->FULL with new data on a drain and load in the same cycle.
REQ-008 The input accepts a beat when din_valid and din_ready are both 1 at a clock edge; only accepted beats change state.
REQ-009 Unicast (bcast=0, sel<NUM_CH): din_ready = dout_valid[sel]==0 OR channel sel drains this cycle; the beat loads only channel sel.
REQ-010 Broadcast (bcast=1): din_ready = 1 only when every channel is EMPTY or draining this cycle; the beat loads all NUM_CH channels in the same edge.
REQ-011 Out-of-range (bcast=0, sel>=NUM_CH): din_ready = 1, the beat is discarded, sel_err sets to 1, and drop_cnt increments, holding at 255.
REQ-012 Latency: an accepted beat appears on dout/dout_valid on the cycle after the accepting edge, with no combinational din->dout path.
REQ-013 din_ready SHALL depend combinationally only on sel, bcast, dout_valid and dout_ready, and never on din_valid.
REQ-014 While dout_valid[k]=1 and dout_ready[k]=0, dout slice k SHALL hold stable.
REQ-015 When a channel goes EMPTY, its dout slice SHALL become all-zero on the same edge; a non-selected channel's dout is therefore 0 unless it holds a pending beat.
REQ-016 Channels drain independently; a stalled channel SHALL block only beats targeting it (or broadcasts), never unicast beats to other channels.
REQ-017 sel_err SHALL clear only on reset.
REQ-018 drop_cnt SHALL not wrap.

Reset
REQ-019 While rst_n=0, the block SHALL hold all outputs at their reset values:
- dout_valid = 0 and all dout bits = 0.
- sel_err = 0 and drop_cnt = 0.
- din_ready = 1 for in-range unicast and for broadcast.
REQ-020 Reset asserted mid-transfer SHALL discard all held beats immediately and asynchronously; the first edge after rst_n rises SHALL be able to accept a beat.

Verification
REQ-021 Defaults; din=8'hA5, sel=2, valid 1 cycle, all ready=1 -> next cycle dout_valid=4'b0100, slice2=8'hA5, slices 0/1/3=0, then EMPTY after one cycle.
REQ-022 Defaults; dout_ready[1]=0, two beats 8'h11 then 8'h22 to sel=1 -> first held; din_ready=0 on the second; raising ready[1] drains 8'h11 and loads 8'h22 on the same edge, dout_valid[1] staying 1.
REQ-023 Defaults; channel 3 stalled FULL, broadcast 8'h5A -> din_ready=0 and unicast to sel=0 still accepted; after channel 3 drains, the broadcast is accepted and all four slices = 8'h5A with dout_valid=4'b1111.
REQ-024 NUM_CH=3; 300 beats with sel=3 -> din_ready=1 throughout, dout_valid stays 0, sel_err=1, drop_cnt=255.
REQ-025 Defaults; rst_n pulsed low while channels 0 and 2 are FULL -> dout_valid=0 and dout=0 immediately; beat 8'h3C to sel=0 on the first edge after release appears the next cycle.
REQ-026 Random valid/ready on NUM_CH=5, DATA_W=16 -> per-channel output sequences equal the scoreboard, with no loss, duplication or reordering.
